i2s_tx: RTL
===========

# i2s_tx

Sink end of the sample pipeline. Accepts 32-bit samples on the `en`/`ready`/`sample_i` stage interface, buffers them in a small FIFO and serializes each one as a stereo I2S frame toward an external DAC. It also generates the pipeline's sample clock: a one-cycle `sample_req` strobe per frame that drives `en` of the first stage in the chain. The last stage's `valid`/`sample_o` connect to this block's `en`/`sample_i`.

## Interface
- `CLK_DIV`, 16: `clk` cycles per `bclk` half-period, ≥2. `bclk` = 100 MHz / (2·CLK_DIV); frame = 128·CLK_DIV cycles (2048 → 48.828 kHz).
- `FIFO_DEPTH`, 4: sample FIFO depth, power of two, ≥2.
- `clk`  in  1  100 MHz bus clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  `sample_i` valid this cycle (upstream `valid`).
- `sample_i`  in  32  sample to transmit.
- `ready`  out  1  registered; high when the FIFO can accept `en` next cycle.
- `sample_req`  out  1  one-cycle pulse per frame start; pipeline sample clock.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  I2S word select; 0 = left, 1 = right.
- `sdata`  out  1  I2S serial data, MSB first.
- `underrun`  out  1  one-cycle pulse: frame started with the FIFO empty.
- `overflow`  out  1  one-cycle pulse: `en` arrived while `ready` was low.

## Operation
- Reset (`rst` low, asynchronous): `ready`, `sample_req`, `bclk`, `lrclk`, `sdata`, `underrun`, `overflow` all 0; FIFO empty; `div_cnt` = 0; `bit_cnt` = 63; shift word = 0.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps; at terminal count `bclk` toggles. `bclk` 0→1 is a rise edge, 1→0 is a fall edge. All I2S outputs change only on fall edges.
- On each fall edge, `bit_cnt` increments mod 64. For new value k:
  - `sdata` = word[31 − (k mod 32)]. The same word is sent in both slots: left at k 0..31, right at k 32..63.
  - `lrclk` = 1 for k in 31..62, 0 for k = 63 and 0..30. This is standard I2S: word select leads the MSB by one bit.
- Frame start is the fall edge entering k = 0:
  - FIFO non-empty: pop into word; `sdata` = word[31].
  - FIFO empty: word = 0; `underrun` pulses.
  - In both cases, `sample_req` pulses for that one `clk` cycle.
- FIFO push: `en` with `ready` high stores `sample_i`. `en` with `ready` low drops the sample and pulses `overflow` the next cycle.
- `ready` <= (count after this cycle's push/pop) < FIFO_DEPTH.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - If empty before the cycle, the pop underruns and the push is stored. No bypass.
- Reset mid-frame: outputs are forced to 0 immediately, buffered samples are discarded, and the timing restart below applies.

## Timing
- After `rst` rises, the first rise edge is at cycle CLK_DIV and the first fall edge (frame start) at cycle 2·CLK_DIV.
- `sample_req` period is exactly 128·CLK_DIV cycles. No jitter.
- `ready` is 1 on the first `clk` edge after reset release, then tracks FIFO occupancy with one-cycle registered latency.
- Latency from push to first transmitted bit is the wait until the next frame start plus any FIFO occupancy ahead of it.
- Closed loop: `sample_req` → chain → `en`. The chain's latency must be below one frame. The sample requested at frame n is transmitted at frame n+1.
- `underrun` and `overflow` are edge-aligned pulses with no stickiness. Counting them is the integrator's job.

## Structure
- Shared package `abies_pkg`: `SAMPLE_W` = 32, `I2S_SLOT_BITS` = 32, `I2S_FRAME_BITS` = 64.
- Sub-module `sample_fifo`:
  - Synchronous FIFO with pointers and count.
  - Ports: push/pop, `full`/`empty`, data in/out; same async active-low reset.
  - Read data is available in the pop cycle (first-word-fall-through).
- Top module `i2s_tx`: divider, bit counter, shift/word register, strobe generation.

## Test plan
- Reset release, CLK_DIV=2, no input → all outputs 0 during reset; `ready` = 1 one cycle after release; first `sample_req` at cycle 4.
- Push 0xA5A5_0F0F before frame 0 → over 64 fall edges, `sdata` = 0xA5A5_0F0F MSB first in both slots; `lrclk` high exactly at k 31..62; no `underrun`.
- No pushes → `sdata` stays 0; `underrun` and `sample_req` pulse together every 256 cycles (CLK_DIV=2).
- Push 0x1, 0x2, 0x3, 0x4, 0x5 back-to-back, FIFO_DEPTH=4 → `ready` falls after the 4th; 0x5 dropped with one `overflow` pulse; frames transmit 1, 2, 3, 4 in order.
- Assert `rst` low at k = 20 with 2 samples queued → outputs 0 immediately; after release, the first frame underruns, proving the FIFO was cleared.
- Closed loop with `buffer` (DELAY=8): `sample_req` drives its `en`, its `valid`/`sample_o` drive `en`/`sample_i`, input is a ramp → after frame 0, every frame carries ramp n+1 and no `underrun` pulses occur.

Source files
------------

// File: rtl/abies_pkg.sv
// Shared sample-pipeline constants and small I2S helpers.
package abies_pkg;

  localparam int SAMPLE_W       = 32;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int BIT_CNT_W      = $clog2(I2S_FRAME_BITS);

  typedef logic [SAMPLE_W-1:0]  sample_t;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // Word select leads the MSB by one bit: high for bits 31..62 of the frame.
  function automatic logic lr_for_bit(input bit_cnt_t k);
    return (k >= bit_cnt_t'(I2S_SLOT_BITS - 1)) && (k <= bit_cnt_t'(I2S_FRAME_BITS - 2));
  endfunction

  // MSB-first bit position inside a slot for frame bit k.
  function automatic logic [4:0] slot_index(input bit_cnt_t k);
    return ~k[4:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous first-word-fall-through FIFO with pointers and occupancy count.
module sample_fifo
  import abies_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  sample_t                wdata,
  output sample_t                rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level_next
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  sample_t       mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level_next = count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers pipeline samples and sends each as a stereo frame,
// emitting the pipeline's per-frame sample_req strobe.
module i2s_tx
  import abies_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                ready,
  output logic                sample_req,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun,
  output logic                overflow
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  bit_cnt_t      bit_cnt_q, bit_cnt_d;
  sample_t       word_q, word_d;
  logic          sdata_q, sdata_d;
  logic          lrclk_q, lrclk_d;
  logic          sample_req_q, sample_req_d;
  logic          underrun_q, underrun_d;
  logic          overflow_q, overflow_d;
  logic          ready_q, ready_d;

  logic          terminal, fall_edge;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  sample_t       fifo_rdata;
  logic [LW-1:0] fifo_level_next;

  assign terminal  = (div_cnt_q == DW'(CLK_DIV - 1));
  assign fall_edge = terminal && bclk_q;
  assign fifo_push = en && ready_q;
  assign ready_d   = (fifo_level_next < LW'(FIFO_DEPTH));

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .wdata      (sample_i),
    .rdata      (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level_next (fifo_level_next)
  );

  always_comb begin
    div_cnt_d    = terminal ? '0 : div_cnt_q + DW'(1);
    bclk_d       = terminal ? ~bclk_q : bclk_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    sdata_d      = sdata_q;
    lrclk_d      = lrclk_q;
    sample_req_d = 1'b0;
    underrun_d   = 1'b0;
    overflow_d   = en && !ready_q;
    fifo_pop     = 1'b0;
    if (fall_edge) begin
      bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
      // Frame start: load the next sample, or send silence if nothing is queued.
      if (bit_cnt_d == '0) begin
        sample_req_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_rdata;
        end else begin
          word_d     = '0;
          underrun_d = 1'b1;
        end
      end
      sdata_d = word_d[slot_index(bit_cnt_d)];
      lrclk_d = lr_for_bit(bit_cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= '1;
      word_q       <= '0;
      sdata_q      <= 1'b0;
      lrclk_q      <= 1'b0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      sdata_q      <= sdata_d;
      lrclk_q      <= lrclk_d;
      sample_req_q <= sample_req_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
      ready_q      <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign sample_req = sample_req_q;
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign underrun   = underrun_q;
  assign overflow   = overflow_q;

endmodule
